iir_ctrl: RTL and testbench

Front-end controller for the advanced IIR filter. It buffers an upstream sample stream and issues samples to the filter's `vin`/`din` input, tracking how many samples are inside the filter pipeline. It holds a shadow and an active bank of the four filter coefficients (`a1`, `a1quad`, `b1`, `b0`). A commit request drains the filter, then swaps banks atomically, so no sample is ever processed with mixed coefficients.

---
 rtl/iir_ctrl.sv | 87 ++++++++
 tb/tb_iir_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_ctrl.sv
// iir_ctrl: buffers the sample stream into the IIR filter, tracks in-flight samples and
// swaps the double-buffered coefficient bank only once the filter pipeline has drained.
module iir_ctrl #(
    parameter int DW = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int IW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    output logic          f_vin,
    output logic [DW-1:0] f_din,
    output logic [DW-1:0] f_a1,
    output logic [DW-1:0] f_a1quad,
    output logic [DW-1:0] f_b1,
    output logic [DW-1:0] f_b0,
    input  logic          f_vout,
    output logic [IW-1:0] inflight,
    output logic          err
);
    typedef enum logic [1:0] {RUN, DRAIN, SWAP} stateE;
    stateE state, nextState;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [DW-1:0] shadow [4];
    logic [DW-1:0] active [4];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count, countNext;
    logic push, pop, retire;
    assign f_a1 = active[0];
    assign f_a1quad = active[1];
    assign f_b1 = active[2];
    assign f_b0 = active[3];
    // A commit cycle issues nothing, so the drain starts from a settled in-flight count.
    always_comb begin
        push = s_valid && s_ready;
        pop = state == RUN && !cfg_commit && count != '0 && inflight < IW'(MAX_INFLIGHT);
        retire = f_vout && inflight != '0;
        countNext = count + (AW+1)'(push) - (AW+1)'(pop);
        nextState = state == RUN ? (cfg_commit ? DRAIN : RUN) :
                    state == DRAIN ? (inflight == '0 ? SWAP : DRAIN) : RUN;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= s_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            s_ready <= 1'b0;
            f_vin <= 1'b0;
            f_din <= '0;
            inflight <= '0;
            err <= 1'b0;
            cfg_busy <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop) begin
                f_din <= mem[rdPtr];
                rdPtr <= rdPtr + AW'(1);
            end
            if (cfg_we) shadow[cfg_addr] <= cfg_wdata;
            if (state == SWAP) active <= shadow;
            f_vin <= pop;
            count <= countNext;
            s_ready <= countNext != (AW+1)'(FIFO_DEPTH);
            inflight <= inflight + IW'(pop) - IW'(retire);
            err <= err || (f_vout && inflight == '0);
            state <= nextState;
            cfg_busy <= nextState != RUN;
        end
    end
endmodule

// File: tb/tb_iir_ctrl.sv
// tb_iir_ctrl: randomized and directed stimulus with a queue scoreboard and a fixed-latency
// filter model that retires each sample on the third rising edge after its f_vin.
module tb_iir_ctrl;
    localparam int DW = 11;
    logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, cfg_we = 1'b0, cfg_commit = 1'b0;
    logic [DW-1:0] s_data = '0, cfg_wdata = '0;
    logic [1:0] cfg_addr = '0;
    logic s_ready, cfg_busy, f_vin, err, f_vout;
    logic [DW-1:0] f_din, f_a1, f_a1quad, f_b1, f_b0;
    logic [2:0] inflight;
    logic filtEn = 1'b0, filterVout = 1'b0, manualVout = 1'b0, errExp = 1'b0;
    logic [1:0] pipe = '0;
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] shadowModel[4], bankModel[4];
    logic [DW-1:0] expVal;
    logic [4*DW-1:0] dutBank;
    int checks = 0, errors = 0, issues = 0, limit = 4, r;

    assign f_vout = filterVout | manualVout;
    assign dutBank = {f_a1, f_a1quad, f_b1, f_b0};
    always #5 clk = ~clk;

    iir_ctrl dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .f_vin(f_vin), .f_din(f_din), .f_a1(f_a1), .f_a1quad(f_a1quad),
        .f_b1(f_b1), .f_b0(f_b0), .f_vout(f_vout), .inflight(inflight), .err(err)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [4*DW-1:0] expBank();
        return {bankModel[0], bankModel[1], bankModel[2], bankModel[3]};
    endfunction

    always @(posedge clk) begin
        #1;
        filterVout = filtEn && pipe[1];
        pipe = rst ? 2'b00 : {pipe[0], f_vin};
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("inflight_limit", 64'(inflight <= limit), 1);
            if (f_vin) begin
                issues++;
                chk("no_issue_busy", cfg_busy, 0);
                chk("err_flag", err, errExp);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got f_din=%0h, expected no issue", f_din);
                end else begin
                    expVal = expQ.pop_front();
                    chk("f_din", f_din, expVal);
                    chk("issue_bank", dutBank, expBank());
                end
            end
        end
    end

    task automatic push(input logic [DW-1:0] v);
        s_valid = 1'b1;
        s_data = v;
        for (int n = 0; n < 60; n++) begin
            if (s_ready) begin
                expQ.push_back(v);
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL push_timeout: s_ready=%0b for sample %0h, expected 1", s_ready, v);
    endtask

    task automatic write(input logic [1:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        shadowModel[a] = d;
    endtask

    task automatic commit(input bit twice);
        logic [4*DW-1:0] old;
        old = expBank();
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) bankModel[i] = shadowModel[i];
        cfg_commit = twice;
        chk("busy_set", cfg_busy, 1);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            cfg_commit = 1'b0;
            if (!cfg_busy) begin
                chk("bank_new", dutBank, expBank());
                chk("swap_inflight", inflight, 0);
                chk("swap_vin", f_vin, 0);
                repeat (4) begin
                    @(posedge clk); #1;
                    chk("busy_once", cfg_busy, 0);
                end
                return;
            end
            chk("bank_hold", dutBank, old);
        end
        checks++;
        errors++;
        $display("FAIL commit_timeout: cfg_busy=%0b after 100 cycles, expected 0", cfg_busy);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 11'h155;
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        manualVout = 1'b0;
        filtEn = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset_outputs", {s_ready, cfg_busy, f_vin, f_din, dutBank, inflight, err}, '0);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        expQ.delete();
        issues = 0;
        errExp = 1'b0;
        limit = 4;
        for (int i = 0; i < 4; i++) begin
            shadowModel[i] = '0;
            bankModel[i] = '0;
        end
        @(posedge clk); #1;
        chk("ready_after_reset", s_ready, 1);
        chk("vin_after_reset", f_vin, 0);
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 400 && expQ.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("drained", expQ.size(), 0);
        chk("inflight_idle", inflight, 0);
    endtask

    initial begin
        resetDut();
        limit = 3;
        filtEn = 1'b1;
        for (int v = 1; v <= 10; v++) push(DW'(v));
        waitDrain();
        chk("stream_issues", issues, 10);
        chk("stream_err", err, 0);

        resetDut();
        for (int v = 1; v <= 6; v++) push(DW'(v * 3));
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("throttle_issues", issues, 4);
        chk("throttle_inflight", inflight, 4);
        chk("throttle_ready_two", s_ready, 1);
        push(11'h0AA);
        chk("throttle_ready_three", s_ready, 1);
        push(11'h0BB);
        chk("throttle_full", s_ready, 0);
        s_valid = 1'b1;
        s_data = 11'h0CC;
        repeat (3) begin
            @(posedge clk); #1;
            chk("throttle_stays_full", s_ready, 0);
        end
        s_valid = 1'b0;
        chk("throttle_held", issues, 4);

        resetDut();
        limit = 3;
        filtEn = 1'b1;
        write(2'd0, 11'h123);
        write(2'd1, 11'h045);
        write(2'd2, 11'h200);
        write(2'd3, 11'h1FF);
        fork
            begin
                for (int v = 0; v < 12; v++) push(DW'(100 + v));
            end
            begin
                repeat (4) begin
                    @(posedge clk); #1;
                end
                commit(1'b1);
            end
        join
        waitDrain();

        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        for (int i = 0; i < 4; i++) bankModel[i] = shadowModel[i];
        chk("swapwr_busy_drain", cfg_busy, 1);
        @(posedge clk); #1;
        chk("swapwr_busy_swap", cfg_busy, 1);
        cfg_we = 1'b1;
        cfg_addr = 2'd3;
        cfg_wdata = 11'h7FF;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        shadowModel[3] = 11'h7FF;
        chk("swapwr_excluded", f_b0, bankModel[3]);
        chk("swapwr_bank", dutBank, expBank());
        chk("swapwr_busy_done", cfg_busy, 0);
        commit(1'b0);
        chk("next_commit_b0", f_b0, 11'h7FF);

        resetDut();
        manualVout = 1'b1;
        @(posedge clk); #1;
        manualVout = 1'b0;
        errExp = 1'b1;
        chk("err_set", err, 1);
        chk("err_count_zero", inflight, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("err_sticky", err, 1);
        push(11'h011);
        push(11'h022);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("err_inflight", inflight, 2);
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("drain_stuck", cfg_busy, 1);
        push(11'h033);
        resetDut();
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("no_stale_issue", issues, 0);
        commit(1'b0);
        limit = 3;
        filtEn = 1'b1;
        push(11'h044);
        waitDrain();

        resetDut();
        limit = 3;
        filtEn = 1'b1;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                push(DW'($urandom));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end else if (r < 8) write(2'($urandom), DW'($urandom));
            else commit(1'b0);
        end
        waitDrain();
        chk("random_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end
endmodule
